mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning width of the requester and RAM address buses.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port flush  input  1  exception flush from ROB.
REQ-005 SHALL have port inst_req  input  1  fetcher word-read request, held until inst_done.
REQ-006 SHALL have port inst_addr  input  ADDR_W  fetch address.
REQ-007 SHALL have port inst_done  output  1  one-cycle completion pulse for a fetch.
REQ-008 SHALL have port inst_data  output  32  fetched word, valid while inst_done=1.
REQ-009 SHALL have port data_req  input  1  store/load-buffer request, held until data_done.
REQ-010 SHALL have port data_we  input  1  1 = store, 0 = load.
REQ-011 SHALL have port data_addr  input  ADDR_W  data address.
REQ-012 SHALL have port data_size  input  2  byte count: 0 = 1 byte, 1 = 2 bytes, 2 = 4 bytes; 3 is treated as 4 bytes.
REQ-013 SHALL have port data_wdata  input  32  store data, little-endian.
REQ-014 SHALL have port data_done  output  1  one-cycle completion pulse for a load or store.
REQ-015 SHALL have port data_rdata  output  32  load data, zero-extended; the store/load buffer sign-extends.
REQ-016 SHALL have port mem_a  output  ADDR_W  RAM byte address.
REQ-017 SHALL have port mem_dout  output  8  RAM write byte.
REQ-018 SHALL have port mem_wr  output  1  RAM write enable.
REQ-019 SHALL have port mem_din  input  8  RAM read byte, valid one cycle after mem_a is presented.

Function
REQ-020 SHALL implement FSM states IDLE, INST_RD, DATA_RD, DATA_WR, plus a byte counter and a last-grant bit.
REQ-021 SHALL, in IDLE with inst_done=0 and data_done=0, grant a single requester at the clock edge:
- inst_req only: grant INST_RD.
- data_req only: grant DATA_RD if data_we=0, else DATA_WR.
- both: grant the requester opposite to last-grant (round-robin); last-grant is updated on every grant.
REQ-022 SHALL ignore all requests during any cycle in which inst_done or data_done is high, so a held request is not granted twice.
REQ-023 SHALL latch address, size, we and wdata at grant; later input changes SHALL NOT affect the transfer.
REQ-024 SHALL handle reads of N bytes as follows:
- Busy cycle k (k = 0..N-1) drives mem_a = addr+k (modulo 2^ADDR_W) with mem_wr=0.
- Byte k is captured from mem_din at the edge ending busy cycle k+1, into bits [8k+7:8k].
- Bytes at or above N read as 0.
REQ-025 SHALL assert the read done pulse, with its data, N+1 edges after the grant edge, then return to IDLE. Word read (fetch or LW) = 5 edges; byte read = 2 edges.
REQ-026 SHALL handle writes of N bytes as follows:
- Busy cycle k drives mem_wr=1, mem_a = addr+k and mem_dout = wdata[8k+7:8k].
- data_done is asserted N edges after the grant edge.
- mem_wr=0 in every cycle not in DATA_WR.
REQ-027 SHALL drive mem_a=0 and mem_dout=0 in IDLE.
REQ-028 SHALL assert inst_done and data_done for exactly one cycle each, never both in the same cycle. inst_data and data_rdata SHALL hold their last value otherwise.
REQ-029 SHALL, when flush=1 in INST_RD or DATA_RD, abort to IDLE at that edge with no done pulse and no data update.
REQ-030 SHALL, when flush=1 in DATA_WR, complete the committed store and pulse data_done as normal.
REQ-031 SHALL, when flush=1 in IDLE, grant only a data_req with data_we=1 at that edge; reads are ignored.
REQ-032 SHALL give rst priority over flush and over all requests.

Reset
REQ-033 SHALL, while rst=1 at an edge, set:
- state = IDLE, counter = 0, last-grant = data (first tie goes to inst).
- mem_a = 0, mem_dout = 0, mem_wr = 0.
- inst_done = 0, data_done = 0, inst_data = 0, data_rdata = 0.
REQ-034 SHALL, on rst mid-transfer, abandon the transfer with no done pulse; mem_wr=0 from the following cycle.

Verification
REQ-035 Fetch: inst_req, addr 0x100, RAM 0x100..0x103 = 13,00,A0,E3 -> mem_a 0x100..0x103 on consecutive cycles; inst_done 5 edges after grant; inst_data = 0xE3A00013.
REQ-036 Store SH: addr 0x2000, wdata 0xDEADBEEF -> two cycles with mem_wr=1 (0x2000/EF, 0x2001/BE); data_done 2 edges after grant; RAM 0x2002 untouched.
REQ-037 Tie: inst_req and data_req (LB, addr 0x10, RAM = 0x80) rise together after reset -> inst granted first; data granted the edge after the inst_done cycle; data_rdata = 0x00000080.
REQ-038 Flush: flush on the 2nd busy cycle of a fetch -> no inst_done, IDLE next cycle. Flush on the 2nd busy cycle of an SW -> all 4 bytes written, data_done pulses.
REQ-039 Wrap and reset: LW at 0xFFFFFFFE -> mem_a FFFFFFFE, FFFFFFFF, 0, 1. rst asserted in the 3rd busy cycle -> all outputs 0 next cycle, no done.
REQ-040 Held request: data_req kept high through data_done -> exactly one transfer, new grant only after one idle cycle.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbitrates a fetcher and a load/store buffer onto a byte-wide single-port RAM.
// Word and half-word transfers are serialised into back-to-back byte accesses.
module mem_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_done,
  output logic [31:0]       inst_data,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [1:0]        data_size,
  input  logic [31:0]       data_wdata,
  output logic              data_done,
  output logic [31:0]       data_rdata,
  output logic [ADDR_W-1:0] mem_a,
  output logic [7:0]        mem_dout,
  output logic              mem_wr,
  input  logic [7:0]        mem_din
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    INST_RD = 2'd1,
    DATA_RD = 2'd2,
    DATA_WR = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        len_q, len_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rbuf_q, rbuf_d;
  logic              inst_done_q, inst_done_d;
  logic              data_done_q, data_done_d;
  logic [31:0]       inst_data_q, inst_data_d;
  logic [31:0]       data_rdata_q, data_rdata_d;

  logic              gnt_inst, gnt_data, pick_inst;
  logic [2:0]        cnt_inc;
  logic [31:0]       rd_merged;

  function automatic logic [2:0] size_to_len(input logic [1:0] size);
    case (size)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] put_byte(input logic [31:0] word, input logic [1:0] idx,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = word;
    case (idx)
      2'd0: r[7:0]   = b;
      2'd1: r[15:8]  = b;
      2'd2: r[23:16] = b;
      default: r[31:24] = b;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] get_byte(input logic [31:0] word, input logic [1:0] idx);
    case (idx)
      2'd0:    return word[7:0];
      2'd1:    return word[15:8];
      2'd2:    return word[23:16];
      default: return word[31:24];
    endcase
  endfunction

  // mem_din lags mem_a by one cycle, so the byte arriving now belongs to address cnt-1.
  assign cnt_inc   = cnt_q + 3'd1;
  assign rd_merged = put_byte(rbuf_q, cnt_q[1:0] - 2'd1, mem_din);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    last_d       = last_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rbuf_d       = rbuf_q;
    inst_done_d  = 1'b0;
    data_done_d  = 1'b0;
    inst_data_d  = inst_data_q;
    data_rdata_d = data_rdata_q;

    gnt_inst  = inst_req && !flush;
    gnt_data  = data_req && (data_we || !flush);
    pick_inst = gnt_inst && (!gnt_data || last_q);

    case (state_q)
      IDLE: begin
        // A requester still holding its request during its done cycle must not be re-granted.
        if (!(inst_done_q || data_done_q) && (gnt_inst || gnt_data)) begin
          cnt_d  = 3'd0;
          rbuf_d = 32'd0;
          last_d = !pick_inst;
          if (pick_inst) begin
            state_d = INST_RD;
            addr_d  = inst_addr;
            len_d   = 3'd4;
          end else begin
            state_d = data_we ? DATA_WR : DATA_RD;
            addr_d  = data_addr;
            len_d   = size_to_len(data_size);
            wdata_d = data_wdata;
          end
        end
      end
      INST_RD, DATA_RD: begin
        if (flush) begin
          state_d = IDLE;
        end else if (cnt_q == len_q) begin
          state_d = IDLE;
          if (state_q == INST_RD) begin
            inst_done_d = 1'b1;
            inst_data_d = rd_merged;
          end else begin
            data_done_d  = 1'b1;
            data_rdata_d = rd_merged;
          end
        end else begin
          cnt_d = cnt_inc;
          if (cnt_q != 3'd0) rbuf_d = rd_merged;
        end
      end
      DATA_WR: begin
        if (cnt_inc == len_q) begin
          state_d     = IDLE;
          data_done_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_a    = '0;
    mem_dout = 8'd0;
    mem_wr   = 1'b0;
    if (state_q != IDLE) mem_a = addr_q + ADDR_W'(cnt_q);
    if (state_q == DATA_WR) begin
      mem_wr   = 1'b1;
      mem_dout = get_byte(wdata_q, cnt_q[1:0]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 3'd0;
      last_q       <= 1'b1;
      inst_done_q  <= 1'b0;
      data_done_q  <= 1'b0;
      inst_data_q  <= 32'd0;
      data_rdata_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_q       <= last_d;
      inst_done_q  <= inst_done_d;
      data_done_q  <= data_done_d;
      inst_data_q  <= inst_data_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  // Transfer context is only consumed outside IDLE, so it needs no reset.
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    len_q   <= len_d;
    wdata_q <= wdata_d;
    rbuf_q  <= rbuf_d;
  end

  assign inst_done  = inst_done_q;
  assign data_done  = data_done_q;
  assign inst_data  = inst_data_q;
  assign data_rdata = data_rdata_q;

endmodule
